// File: rtl/sum_collector.sv
// sum_collector: collects {cout, psum} results from a fixed-latency pipelined
// 16-bit adder into a small FIFO. The block only tracks which adder cycles
// carry real transactions (a bit-wide shift register) and hands out credit
// so the FIFO can never overflow.
module sum_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              psum_in,
  input  logic                     cout_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [16:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] r_vld_pipe;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_count;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [16:0]        r_mem [DEPTH];
  logic               r_drop_err;

  logic [CW:0]        w_credit;
  logic               w_ready;
  logic               w_accept;
  logic               w_capture;
  logic               w_pop;

  // Credit looks only at registered occupancy, so a pop in this cycle frees
  // a slot starting next cycle.
  assign w_credit  = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_ready   = w_credit < (CW+1)'(DEPTH);
  assign w_accept  = in_valid & w_ready;
  assign w_capture = r_vld_pipe[LATENCY-1];
  assign w_pop     = (r_count != '0) & out_ready;

  assign in_ready  = w_ready;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rptr];
  assign count     = r_count;
  assign drop_err  = r_drop_err;

  // Accept bit travels alongside the adder; it emerges on the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  // Transactions inside the adder that still own a FIFO slot.
  always_ff @(posedge clk) begin
    if (rst)                         r_inflight <= '0;
    else if (w_accept && !w_capture) r_inflight <= r_inflight + CW'(1);
    else if (!w_accept && w_capture) r_inflight <= r_inflight - CW'(1);
  end

  // FIFO occupancy; a simultaneous capture and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst)                      r_count <= '0;
    else if (w_capture && !w_pop) r_count <= r_count + CW'(1);
    else if (!w_capture && w_pop) r_count <= r_count - CW'(1);
  end

  // Storage and pointers; storage is cleared so out_data is never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_capture) begin
        r_mem[r_wptr] <= {cout_in, psum_in};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
    end
  end

  // Sticky: the feeder presented a transaction without credit.
  always_ff @(posedge clk) begin
    if (rst)                     r_drop_err <= 1'b0;
    else if (in_valid && !w_ready) r_drop_err <= 1'b1;
  end

  // Credit guarantees a free slot on every capture.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_capture && r_count == CW'(DEPTH)));

endmodule

// File: tb/tb_sum_collector.sv
// Bench for sum_collector: a behavioural LATENCY-stage adder feeds the DUT,
// accepted operands push expected sums into a queue, and a monitor pops and
// compares on every output handshake. Directed checks cover timing points.
module tb_sum_collector;
  localparam int LAT = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, cout_in, drop_err;
  logic [15:0] psum_in;
  logic [16:0] out_data;
  logic [2:0]  count;

  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        op_c = 1'b0;
  logic [16:0] add_pipe [LAT];
  logic [16:0] exp_q [$];

  int n_checks = 0;
  int n_err    = 0;
  int n_pops   = 0;

  always #5 clk = ~clk;

  sum_collector #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .psum_in(psum_in), .cout_in(cout_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count),
    .drop_err(drop_err)
  );

  // Upstream adder: samples operands every edge, sum appears LAT edges later.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) add_pipe[i] <= '0;
    end else begin
      add_pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + {16'b0, op_c};
      for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign psum_in = add_pipe[LAT-1][15:0];
  assign cout_in = add_pipe[LAT-1][16];

  // Stimulus side: every accepted transaction pushes its expected result.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (in_valid && in_ready)
      exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {16'b0, op_c});
  end

  // Monitor: compare each popped result against the oldest expectation.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && out_valid && out_ready) begin
      n_pops++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_pop: got %05h, expected no result", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL sb_data: got %05h, expected %05h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    in_valid = v;
    op_a = a;
    op_b = b;
    op_c = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc, issued, maxc, p0, cyc;
    logic rdy;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_count",     count,     0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_drop_err",  drop_err,  0);
    rst = 1'b0;

    // Single op, accepted at edge 0: 0x1234 + 0x0FFF + 1 = 0x02234
    setop(1, 16'h1234, 16'h0FFF, 1); tick();
    setop(0, 0, 0, 0); tick(); tick(); tick();
    chk("single_early", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_data",  out_data,  17'h02234);
    chk("single_count", count,     1);
    out_ready = 1; tick(); out_ready = 0;
    chk("single_drain", count, 0);

    // Carry out
    setop(1, 16'hFFFF, 16'h0001, 0); tick();
    setop(1, 16'h8000, 16'h8000, 1); tick();
    setop(0, 0, 0, 0); tick(); tick(); tick(); tick();
    chk("carry_count2", count,    2);
    chk("carry_data0",  out_data, 17'h10000);
    out_ready = 1; tick();
    chk("carry_data1",  out_data, 17'h10001);
    chk("carry_count1", count,    1);
    tick(); out_ready = 0;
    chk("carry_count0", count,    0);

    // Fill / credit with out_ready low
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      setop(1, 16'(i * 16'h1111), 16'(i + 1), i[0]);
      rdy = in_ready;
      tick();
      if (rdy) acc++;
      if (i == 3) begin
        chk("fill_ready_low", in_ready, 0);
        chk("fill_no_drop",   drop_err, 0);
      end
      if (i == 4) chk("fill_drop_set", drop_err, 1);
      if (i == 6) chk("fill_count3",   count,    3);
      if (i == 7) chk("fill_count4",   count,    4);
    end
    setop(0, 0, 0, 0);
    chk("fill_accepts", acc, 4);
    out_ready = 1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    out_ready = 0;
    chk("fill_drained",  exp_q.size(), 0);
    chk("fill_count0",   count,        0);
    chk("fill_sticky",   drop_err,     1);
    rst = 1; tick(); rst = 0;
    chk("clr_drop_err", drop_err, 0);

    // Streaming with the consumer always ready
    issued = 0; maxc = 0; p0 = n_pops;
    for (cyc = 0; cyc < 300 && (issued < 20 || exp_q.size() != 0); cyc++) begin
      out_ready = 1;
      if (issued < 20 && in_ready) begin
        setop(1, 16'($urandom), 16'($urandom), 1'($urandom));
        issued++;
      end else setop(0, 0, 0, 0);
      tick();
      if (int'(count) > maxc) maxc = int'(count);
    end
    setop(0, 0, 0, 0); out_ready = 0;
    chk("stream_issued",  issued,       20);
    chk("stream_pops",    n_pops - p0,  20);
    chk("stream_left",    exp_q.size(), 0);
    chk("stream_no_drop", drop_err,     0);
    chk("stream_maxcnt",  maxc <= 1,    1);

    // Toggling consumer, exercising simultaneous capture/pop and wrap
    issued = 0; maxc = 0; p0 = n_pops;
    for (cyc = 0; cyc < 300 && (issued < 10 || exp_q.size() != 0); cyc++) begin
      out_ready = cyc[0];
      if (issued < 10 && in_ready) begin
        setop(1, 16'(16'h0F00 + cyc * 16'h0123), 16'(16'hF0F0 - cyc), cyc[1]);
        issued++;
      end else setop(0, 0, 0, 0);
      tick();
      if (int'(count) > maxc) maxc = int'(count);
    end
    setop(0, 0, 0, 0); out_ready = 0;
    chk("toggle_pops",    n_pops - p0, 10);
    chk("toggle_maxcnt",  maxc <= DEP, 1);
    chk("toggle_no_drop", drop_err,    0);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) begin
      setop(1, 16'(16'h4000 + i), 16'h0101, 0);
      tick();
    end
    setop(0, 0, 0, 0);
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_valid", out_valid, 0);
    end
    chk("midrst_count", count,        0);
    chk("midrst_ready", in_ready,     1);
    chk("midrst_drop",  drop_err,     0);
    chk("midrst_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
